// File: rtl/cmdproc_pkg.sv
// Shared definitions for the multi-channel command processor: opcodes,
// result codes, FSM state encoding, reset defaults and small helpers.
package cmdproc_pkg;

  // Per-channel and global opcodes (i_cmd[7:0])
  localparam logic [7:0] OP_RUN_ON   = 8'd1;
  localparam logic [7:0] OP_RUN_OFF  = 8'd2;
  localparam logic [7:0] OP_OUTMODE  = 8'd3;
  localparam logic [7:0] OP_OUTNEG   = 8'd4;
  localparam logic [7:0] OP_FREQ     = 8'd5;
  localparam logic [7:0] OP_ACQ      = 8'd6;
  localparam logic [7:0] OP_OUTDLY   = 8'd7;
  localparam logic [7:0] OP_WAVEDLY  = 8'd8;
  localparam logic [7:0] OP_TEST     = 8'd9;
  localparam logic [7:0] OP_GAIN     = 8'd10;
  localparam logic [7:0] OP_CLR_OVF  = 8'd11;

  // Full-word special commands
  localparam logic [15:0] CMD_SET_SERVER = 16'hFFFE;
  localparam logic [15:0] CMD_NOP        = 16'hFFFD;

  // Result codes reported on o_finish_code
  localparam logic [15:0] ERR_OK    = 16'd0;
  localparam logic [15:0] ERR_IDENT = 16'd1;
  localparam logic [15:0] ERR_CHAN  = 16'd2;
  localparam logic [15:0] ERR_DIV0  = 16'd3;
  localparam logic [15:0] ERR_OPC   = 16'd4;

  // One-hot FSM encoding
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_FETCH = 6'b000010,
    ST_EXEC  = 6'b000100,
    ST_DIV   = 6'b001000,
    ST_HOLD  = 6'b010000,
    ST_DONE  = 6'b100000
  } state_t;

  // Register reset defaults
  localparam logic [19:0] DEF_CYCLE   = 20'd1000000;
  localparam logic [11:0] DEF_PULSE   = 12'd100;
  localparam logic [7:0]  DEF_GAIN    = 8'd100;
  localparam logic [15:0] DEF_RAWSIZE = 16'd32;
  localparam logic [2:0]  DEF_RATE    = 3'd1;

  // Opcodes that honour the channel field
  function automatic logic is_chan_op(input logic [7:0] op);
    return op inside {OP_RUN_ON, OP_RUN_OFF, OP_OUTMODE, OP_OUTNEG, OP_FREQ,
                      OP_OUTDLY, OP_WAVEDLY, OP_GAIN};
  endfunction

  // Opcodes that act on global settings and ignore the channel field
  function automatic logic is_global_op(input logic [7:0] op);
    return op inside {OP_ACQ, OP_TEST, OP_CLR_OVF};
  endfunction

  // Clamp a quotient into the 20-bit period field
  function automatic logic [19:0] sat20(input logic [31:0] q);
    return (q[31:20] != 12'd0) ? 20'hFFFFF : q[19:0];
  endfunction

  // Clamp a quotient into the 12-bit pulse field
  function automatic logic [11:0] sat12(input logic [31:0] q);
    return (q[31:12] != 20'd0) ? 12'hFFF : q[11:0];
  endfunction

endpackage

// File: rtl/seq_div.sv
// 32-bit by 16-bit unsigned restoring divider. One quotient bit per clock,
// 32 clocks from i_start to the o_done pulse. Divisor must be non-zero.
module seq_div (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [15:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic        o_done
);

  logic [15:0] rem;
  logic [15:0] dsr;
  logic [31:0] quo;
  logic [5:0]  cnt;
  logic        active;
  logic [16:0] trial;
  logic        take;
  logic [15:0] diff_lo;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  // When the subtract succeeds the result is below the divisor, so 16 bits suffice.
  assign trial   = {rem, quo[31]};
  assign take    = (trial >= {1'b0, dsr});
  assign diff_lo = trial[15:0] - dsr;

  assign o_quotient = quo;

  // Iterate one restoring step per clock; quotient bits shift in from the right
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem    <= '0;
      dsr    <= '0;
      quo    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        rem    <= '0;
        dsr    <= i_divisor;
        quo    <= i_dividend;
        cnt    <= 6'd32;
        active <= 1'b1;
      end else if (active) begin
        rem <= take ? diff_lo : trial[15:0];
        quo <= {quo[30:0], take};
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          active <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmdproc_mc.sv
// Multi-channel command processor. Host commands arrive with an asynchronous
// strobe, are queued in a small FIFO and executed one at a time. Results drive
// per-channel trigger/gain registers and global acquisition settings.
// Handshake: a falling edge of the synchronised strobe is a single-cycle push;
// there is no back-pressure, so a push into a full queue is dropped and latched
// in o_ovf until opcode 11 clears it. o_finish is a one-cycle completion pulse
// and o_finish_code holds that command's result until the next completion.
module cmdproc_mc
  import cmdproc_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] IDENT       = 32'hFEFEEFEF,
  parameter int          SERVER_WAIT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_come,
  input  logic [15:0]          i_cmd,
  input  logic [31:0]          i_cmd_param,
  output logic [NUM_CH-1:0]    o_run,
  output logic [NUM_CH-1:0]    o_outmode,
  output logic [NUM_CH-1:0]    o_outnegedge,
  output logic [NUM_CH*20-1:0] o_cycle,
  output logic [NUM_CH*12-1:0] o_pulse,
  output logic [NUM_CH*16-1:0] o_outdelay,
  output logic [NUM_CH*16-1:0] o_wavedelay,
  output logic [NUM_CH*8-1:0]  o_gaindata,
  output logic [15:0]          o_waveRawSize,
  output logic [2:0]           o_waveRate,
  output logic                 o_test,
  output logic                 o_busy,
  output logic                 o_finish,
  output logic [15:0]          o_finish_code,
  output logic                 o_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- strobe synchroniser ----------------
  logic come_s1, come_s2, come_d;
  logic cmd_fall;

  // Two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      come_s1 <= 1'b1;
      come_s2 <= 1'b1;
      come_d  <= 1'b1;
    end else begin
      come_s1 <= i_cmd_come;
      come_s2 <= come_s1;
      come_d  <= come_s2;
    end
  end

  assign cmd_fall = come_d & ~come_s2;

  // ---------------- command FIFO ----------------
  logic [47:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        pop, do_write, ovf_clr;
  logic [47:0] fifo_head;
  state_t      state;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign do_write   = cmd_fall && (!fifo_full || pop);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  // Pointer update and sticky overflow; a drop outranks a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (cmd_fall && !do_write) o_ovf <= 1'b1;
      else if (ovf_clr)          o_ovf <= 1'b0;
    end
  end

  // Queue storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (do_write) fifo_mem[wr_ptr[AW-1:0]] <= {i_cmd, i_cmd_param};
  end

  // ---------------- decode of the current command ----------------
  logic [15:0]       cmd_q;
  logic [31:0]       param_q;
  logic [7:0]        opcode;
  logic [3:0]        chan;
  logic [NUM_CH-1:0] ch_mask;
  logic              ch_ok;
  logic [15:0]       exec_code;
  logic              is_server, is_nop, freq_go;

  assign opcode    = cmd_q[7:0];
  assign chan      = cmd_q[11:8];
  assign is_server = (cmd_q == CMD_SET_SERVER);
  assign is_nop    = (cmd_q == CMD_NOP);

  // Channel field to target mask; 4'hF selects every channel
  always_comb begin
    ch_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan == 4'hF || chan == 4'(c)) ch_mask[c] = 1'b1;
    end
  end

  assign ch_ok = |ch_mask;

  // Result code for the command as decoded, before any division
  always_comb begin
    exec_code = ERR_OK;
    if (is_server || is_nop) begin
      exec_code = ERR_OK;
    end else if (cmd_q[15:12] != 4'h0) begin
      exec_code = ERR_OPC;
    end else if (is_chan_op(opcode)) begin
      if (!ch_ok)                                           exec_code = ERR_CHAN;
      else if (opcode == OP_FREQ && param_q[15:0] == 16'd0) exec_code = ERR_DIV0;
    end else if (!is_global_op(opcode)) begin
      exec_code = ERR_OPC;
    end
  end

  assign freq_go = (exec_code == ERR_OK) && !is_server && !is_nop && (opcode == OP_FREQ);

  // ---------------- shared divider ----------------
  logic        div_start, div_done, div_phase;
  logic [31:0] div_dividend, div_quotient;
  logic [15:0] div_divisor;
  logic [19:0] cyc_res;
  logic [31:0] hold_cnt;

  seq_div u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (div_start),
    .i_dividend (div_dividend),
    .i_divisor  (div_divisor),
    .o_quotient (div_quotient),
    .o_done     (div_done)
  );

  assign o_busy = (state != ST_IDLE) || !fifo_empty;

  // Command sequencer; all output registers change only on entry to DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      cmd_q         <= '0;
      param_q       <= '0;
      div_start     <= 1'b0;
      div_phase     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      cyc_res       <= '0;
      hold_cnt      <= '0;
      ovf_clr       <= 1'b0;
      o_finish      <= 1'b0;
      o_finish_code <= ERR_OK;
      o_run         <= '0;
      o_outmode     <= '0;
      o_outnegedge  <= '0;
      o_cycle       <= {NUM_CH{DEF_CYCLE}};
      o_pulse       <= {NUM_CH{DEF_PULSE}};
      o_outdelay    <= '0;
      o_wavedelay   <= '0;
      o_gaindata    <= {NUM_CH{DEF_GAIN}};
      o_waveRawSize <= DEF_RAWSIZE;
      o_waveRate    <= DEF_RATE;
      o_test        <= 1'b0;
    end else begin
      o_finish  <= 1'b0;
      div_start <= 1'b0;
      ovf_clr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {cmd_q, param_q} <= fifo_head;
            state            <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (is_server) begin
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end else if (freq_go) begin
            div_start    <= 1'b1;
            div_phase    <= 1'b0;
            div_dividend <= 32'(CLK_HZ);
            div_divisor  <= param_q[15:0];
            state        <= ST_DIV;
          end else begin
            state         <= ST_DONE;
            o_finish      <= 1'b1;
            o_finish_code <= exec_code;
            if (exec_code == ERR_OK && !is_nop) begin
              for (int c = 0; c < NUM_CH; c++) begin
                if (ch_mask[c]) begin
                  case (opcode)
                    OP_RUN_ON:  o_run[c]               <= 1'b1;
                    OP_RUN_OFF: o_run[c]               <= 1'b0;
                    OP_OUTMODE: o_outmode[c]           <= param_q[0];
                    OP_OUTNEG:  o_outnegedge[c]        <= param_q[0];
                    OP_OUTDLY:  o_outdelay[c*16 +: 16] <= param_q[15:0];
                    OP_WAVEDLY: o_wavedelay[c*16 +: 16] <= param_q[15:0];
                    OP_GAIN:    o_gaindata[c*8 +: 8]   <= param_q[7:0];
                    default: ;
                  endcase
                end
              end
              case (opcode)
                OP_ACQ: begin
                  o_waveRate    <= param_q[18:16];
                  o_waveRawSize <= param_q[15:0];
                end
                OP_TEST:    o_test  <= param_q[0];
                OP_CLR_OVF: ovf_clr <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        ST_DIV: begin
          if (div_done) begin
            if (!div_phase) begin
              cyc_res <= sat20(div_quotient);
              if (param_q[31:16] != 16'd0) begin
                div_start    <= 1'b1;
                div_phase    <= 1'b1;
                div_dividend <= {16'd0, param_q[31:16]};
                div_divisor  <= 16'd10;
              end else begin
                state         <= ST_DONE;
                o_finish      <= 1'b1;
                o_finish_code <= ERR_OK;
                for (int c = 0; c < NUM_CH; c++) begin
                  if (ch_mask[c]) o_cycle[c*20 +: 20] <= sat20(div_quotient);
                end
              end
            end else begin
              state         <= ST_DONE;
              o_finish      <= 1'b1;
              o_finish_code <= ERR_OK;
              for (int c = 0; c < NUM_CH; c++) begin
                if (ch_mask[c]) begin
                  o_cycle[c*20 +: 20] <= cyc_res;
                  o_pulse[c*12 +: 12] <= sat12(div_quotient);
                end
              end
            end
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 32'd1;
          if (hold_cnt == 32'(SERVER_WAIT - 1)) begin
            state         <= ST_DONE;
            o_finish      <= 1'b1;
            o_finish_code <= (param_q == IDENT) ? ERR_OK : ERR_IDENT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmdproc_mc.sv
// Directed bench for cmdproc_mc: expected result codes are queued as commands
// are issued and a monitor pops one per o_finish pulse; register contents are
// compared against hand-computed values once the processor goes idle.
module tb_cmdproc_mc;

  localparam int          NUM_CH      = 4;
  localparam int          SERVER_WAIT = 32;
  localparam logic [31:0] IDENT       = 32'hFEFEEFEF;

  logic                 i_clk, i_rst_n, i_cmd_come;
  logic [15:0]          i_cmd;
  logic [31:0]          i_cmd_param;
  logic [NUM_CH-1:0]    o_run, o_outmode, o_outnegedge;
  logic [NUM_CH*20-1:0] o_cycle;
  logic [NUM_CH*12-1:0] o_pulse;
  logic [NUM_CH*16-1:0] o_outdelay, o_wavedelay;
  logic [NUM_CH*8-1:0]  o_gaindata;
  logic [15:0]          o_waveRawSize;
  logic [2:0]           o_waveRate;
  logic                 o_test, o_busy, o_finish, o_ovf;
  logic [15:0]          o_finish_code;

  logic [15:0] exp_q[$];
  logic [15:0] exp_head;
  int          n_vec, n_err;
  int          lat;

  cmdproc_mc #(
    .NUM_CH(NUM_CH), .CLK_HZ(100000000), .FIFO_DEPTH(4),
    .IDENT(IDENT), .SERVER_WAIT(SERVER_WAIT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_come(i_cmd_come),
    .i_cmd(i_cmd), .i_cmd_param(i_cmd_param),
    .o_run(o_run), .o_outmode(o_outmode), .o_outnegedge(o_outnegedge),
    .o_cycle(o_cycle), .o_pulse(o_pulse), .o_outdelay(o_outdelay),
    .o_wavedelay(o_wavedelay), .o_gaindata(o_gaindata),
    .o_waveRawSize(o_waveRawSize), .o_waveRate(o_waveRate), .o_test(o_test),
    .o_busy(o_busy), .o_finish(o_finish), .o_finish_code(o_finish_code),
    .o_ovf(o_ovf)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest expected code
  always @(negedge i_clk) begin
    if (i_rst_n && o_finish) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_finish: got code %0h expected no completion", o_finish_code);
      end else begin
        exp_head = exp_q.pop_front();
        check("finish_code", {16'd0, o_finish_code}, {16'd0, exp_head});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One strobe: low for two clocks, high for two clocks
  task automatic strobe(input logic [15:0] cmd, input logic [31:0] param);
    @(negedge i_clk);
    i_cmd       = cmd;
    i_cmd_param = param;
    i_cmd_come  = 1'b0;
    repeat (2) @(negedge i_clk);
    i_cmd_come = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  // Strobe and count clock edges until o_finish is seen (processor must be idle)
  task automatic send_timed(input logic [15:0] cmd, input logic [31:0] param, output int n);
    @(negedge i_clk);
    i_cmd       = cmd;
    i_cmd_param = param;
    i_cmd_come  = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
      if (n == 2) i_cmd_come = 1'b1;
      if (o_finish) break;
    end
    i_cmd_come = 1'b1;
  endtask

  // Wait until every expected completion has arrived and the processor is idle
  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < 3000) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
    end
    @(negedge i_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    i_rst_n = 1'b0;
    i_cmd_come = 1'b1;
    i_cmd = '0;
    i_cmd_param = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Reset values
    check("rst_run", {28'd0, o_run}, 32'd0);
    check("rst_outmode", {28'd0, o_outmode}, 32'd0);
    check("rst_outneg", {28'd0, o_outnegedge}, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      check("rst_cycle", {12'd0, o_cycle[c*20 +: 20]}, 32'd1000000);
      check("rst_pulse", {20'd0, o_pulse[c*12 +: 12]}, 32'd100);
      check("rst_gain", {24'd0, o_gaindata[c*8 +: 8]}, 32'd100);
      check("rst_outdly", {16'd0, o_outdelay[c*16 +: 16]}, 32'd0);
      check("rst_wavedly", {16'd0, o_wavedelay[c*16 +: 16]}, 32'd0);
    end
    check("rst_rawsize", {16'd0, o_waveRawSize}, 32'd32);
    check("rst_rate", {29'd0, o_waveRate}, 32'd1);
    check("rst_test", {31'd0, o_test}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_finish", {31'd0, o_finish}, 32'd0);
    check("rst_ovf", {31'd0, o_ovf}, 32'd0);
    check("rst_code", {16'd0, o_finish_code}, 32'd0);

    // Run ch2: 3 sync/edge clocks + 3 clocks after the FIFO write
    exp_q.push_back(16'd0);
    send_timed(16'h0201, 32'd0, lat);
    check("run_latency", lat, 32'd6);
    wait_done("run");
    check("run_ch2", {28'd0, o_run}, 32'h4);

    // Broadcast freq: 1e8/10000 = 10000, 1000/10 = 100
    exp_q.push_back(16'd0);
    strobe(16'h0F05, 32'h03E8_2710);
    wait_done("freq_bcast");
    for (int c = 0; c < NUM_CH; c++)
      check("freq_bcast_cycle", {12'd0, o_cycle[c*20 +: 20]}, 32'd10000);
    check("freq_bcast_pulse", {20'd0, o_pulse[12 +: 12]}, 32'd100);

    // ch1: 1e8/1000 = 100000, 10000/10 = 1000
    exp_q.push_back(16'd0);
    strobe(16'h0105, 32'h2710_03E8);
    wait_done("freq_ch1");
    check("freq_ch1_cycle", {12'd0, o_cycle[20 +: 20]}, 32'd100000);
    check("freq_ch1_pulse", {20'd0, o_pulse[12 +: 12]}, 32'd1000);
    check("freq_ch0_kept", {12'd0, o_cycle[0 +: 20]}, 32'd10000);

    // Divide by zero: code 3, nothing changes
    exp_q.push_back(16'd3);
    strobe(16'h0F05, 32'h0001_0000);
    wait_done("div0");
    check("div0_cycle0", {12'd0, o_cycle[0 +: 20]}, 32'd10000);
    check("div0_cycle1", {12'd0, o_cycle[20 +: 20]}, 32'd100000);

    // Channel 9 does not exist
    exp_q.push_back(16'd2);
    strobe(16'h0905, 32'd1);
    wait_done("bad_chan");

    // 1e8/50 = 2e6 saturates the 20-bit field; pulse untouched
    exp_q.push_back(16'd0);
    strobe(16'h0005, 32'd50);
    wait_done("sat_cycle");
    check("sat_cycle", {12'd0, o_cycle[0 +: 20]}, 32'hFFFFF);
    check("sat_cycle_pulse", {20'd0, o_pulse[0 +: 12]}, 32'd100);

    // 1e8/1 saturates; 65535/10 = 6553 saturates the 12-bit pulse
    exp_q.push_back(16'd0);
    strobe(16'h0305, 32'hFFFF_0001);
    wait_done("sat_pulse");
    check("sat_pulse_cycle", {12'd0, o_cycle[60 +: 20]}, 32'hFFFFF);
    check("sat_pulse", {20'd0, o_pulse[36 +: 12]}, 32'hFFF);

    // Server identity
    exp_q.push_back(16'd0);
    send_timed(16'hFFFE, IDENT, lat);
    check("server_wait", {31'd0, (lat >= SERVER_WAIT && lat <= SERVER_WAIT + 10)}, 32'd1);
    wait_done("server_ok");
    exp_q.push_back(16'd1);
    strobe(16'hFFFE, 32'd0);
    wait_done("server_bad");

    // Remaining simple opcodes
    exp_q.push_back(16'd0); strobe(16'h0F03, 32'd1);
    exp_q.push_back(16'd0); strobe(16'h0104, 32'd1);
    exp_q.push_back(16'd0); strobe(16'h0207, 32'h0000_1234);
    exp_q.push_back(16'd0); strobe(16'h0308, 32'h0000_ABCD);
    exp_q.push_back(16'd0); strobe(16'h0706, 32'h0005_0100);
    exp_q.push_back(16'd0); strobe(16'h0009, 32'd1);
    exp_q.push_back(16'd0); strobe(16'h0202, 32'd0);
    exp_q.push_back(16'd4); strobe(16'h00FF, 32'd0);
    exp_q.push_back(16'd0); strobe(16'hFFFD, 32'd0);
    wait_done("simple_ops");
    check("outmode", {28'd0, o_outmode}, 32'hF);
    check("outneg", {28'd0, o_outnegedge}, 32'h2);
    check("outdly_ch2", {16'd0, o_outdelay[32 +: 16]}, 32'h1234);
    check("wavedly_ch3", {16'd0, o_wavedelay[48 +: 16]}, 32'hABCD);
    check("rawsize", {16'd0, o_waveRawSize}, 32'h0100);
    check("rate", {29'd0, o_waveRate}, 32'd5);
    check("test", {31'd0, o_test}, 32'd1);
    check("run_off", {28'd0, o_run}, 32'd0);

    // Overflow: long freq command, then six strobes; four queue, two drop
    exp_q.push_back(16'd0); strobe(16'h0005, 32'h03E8_2710);
    exp_q.push_back(16'd0); strobe(16'h000A, 32'h0000_0055);
    exp_q.push_back(16'd2); strobe(16'h090A, 32'd1);
    exp_q.push_back(16'd4); strobe(16'h00EE, 32'd0);
    exp_q.push_back(16'd0); strobe(16'hFFFD, 32'd0);
    strobe(16'h010A, 32'h0000_0077);
    strobe(16'h020A, 32'h0000_0066);
    wait_done("overflow");
    check("ovf_set", {31'd0, o_ovf}, 32'd1);
    check("ovf_gain0", {24'd0, o_gaindata[0 +: 8]}, 32'h55);
    check("ovf_gain1_dropped", {24'd0, o_gaindata[8 +: 8]}, 32'd100);
    check("ovf_gain2_dropped", {24'd0, o_gaindata[16 +: 8]}, 32'd100);
    check("ovf_cycle0", {12'd0, o_cycle[0 +: 20]}, 32'd10000);
    exp_q.push_back(16'd0);
    strobe(16'h000B, 32'd0);
    wait_done("ovf_clear");
    check("ovf_cleared", {31'd0, o_ovf}, 32'd0);

    // Reset in the middle of a division: no completion, registers back to defaults
    strobe(16'h0005, 32'h03E8_0064);
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (100) @(negedge i_clk);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_cycle0", {12'd0, o_cycle[0 +: 20]}, 32'd1000000);
    check("midrst_gain0", {24'd0, o_gaindata[0 +: 8]}, 32'd100);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
